cp0_req_sched: RTL

- Scheduler in front of the single-ported CP0 register file of the dual-issue core.
- Arbitrates CP0 traffic from both issue slots: exceptions, eret, mtc0 and mfc0.
- Serialises same-cycle double CP0 accesses by stalling issue for one cycle.
- Synchronises hardware interrupt lines and injects interrupts at a clean instruction boundary; sequences the post-exception/eret flush window.

---
 rtl/cp0_req_sched_pkg.sv | 91 +++++++++
 rtl/cp0_req_sched_exc_prio.sv | 53 +++++
 rtl/cp0_req_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cp0_req_sched_pkg.sv
// -----------------------------------------------------------------------------
// cp0_req_sched_pkg
// Shared definitions for the CP0 request scheduler:
//   - instruction exception-info layout (width and bit positions)
//   - MIPS ExcCode values produced by the scheduler
//   - scheduler state encoding
//   - the per-slot CP0 request record and a helper that builds it
// -----------------------------------------------------------------------------
package cp0_req_sched_pkg;

    localparam int EXCEPTINFO_WD = 16;

    // Bit positions inside the 16-bit exception-info word
    localparam int INFO_ADDR_HI = 15;
    localparam int INFO_ADDR_LO = 11;
    localparam int INFO_BD      = 10;
    localparam int INFO_PCADDR  = 9;
    localparam int INFO_ADES    = 8;
    localparam int INFO_ADEL    = 7;
    localparam int INFO_OV      = 6;
    localparam int INFO_SYS     = 5;
    localparam int INFO_BRK     = 4;
    localparam int INFO_RI      = 3;
    localparam int INFO_ERET    = 2;
    localparam int INFO_MFC0    = 1;
    localparam int INFO_MTC0    = 0;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE2 = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    // Everything the scheduler can present to CP0 in one cycle
    typedef struct packed {
        logic        we;
        logic        re;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        except;
        logic [4:0]  excode;
        logic        eret;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic        bd;
    } req_t;

    // Turn one slot's decoded fields into the CP0 request it would issue if
    // granted. Exception beats eret, eret beats register access, and mtc0
    // beats mfc0 so only a single access is ever performed per slot.
    function automatic req_t build_req(
        input logic                     exc,
        input logic [4:0]               excode,
        input logic [31:0]              badaddr,
        input logic [EXCEPTINFO_WD-1:0] info,
        input logic [31:0]              pc,
        input logic [31:0]              wdata
    );
        req_t r;
        r = '0;
        if (exc) begin
            r.except  = 1'b1;
            r.excode  = excode;
            r.pc      = pc;
            r.badaddr = badaddr;
            r.bd      = info[INFO_BD];
        end else if (info[INFO_ERET]) begin
            r.eret = 1'b1;
            r.pc   = pc;
            r.bd   = info[INFO_BD];
        end else if (info[INFO_MTC0]) begin
            r.we    = 1'b1;
            r.addr  = info[INFO_ADDR_HI:INFO_ADDR_LO];
            r.wdata = wdata;
        end else if (info[INFO_MFC0]) begin
            r.re   = 1'b1;
            r.addr = info[INFO_ADDR_HI:INFO_ADDR_LO];
        end
        return r;
    endfunction

endpackage

// File: rtl/cp0_req_sched_exc_prio.sv
// -----------------------------------------------------------------------------
// cp0_exc_prio
// Combinational exception prioritiser for one issue slot.
// Ports:
//   info        in  exception-info word of the slot
//   pc          in  instruction PC
//   badaddr     in  faulting data address
//   exc         out slot raises a synchronous exception
//   excode      out ExcCode of the highest-priority exception
//   badaddr_sel out BadVAddr source (pc for fetch faults, data address for
//                   load/store faults, 0 otherwise)
// -----------------------------------------------------------------------------
module cp0_exc_prio
    import cp0_req_sched_pkg::*;
(
    input  logic [EXCEPTINFO_WD-1:0] info,
    input  logic [31:0]              pc,
    input  logic [31:0]              badaddr,
    output logic                     exc,
    output logic [4:0]               excode,
    output logic [31:0]              badaddr_sel
);

    logic unused_info;
    assign unused_info = ^{info[INFO_ADDR_HI:INFO_BD], info[INFO_ERET:INFO_MTC0]};

    assign exc = |info[INFO_PCADDR:INFO_RI];

    always_comb begin
        excode      = 5'd0;
        badaddr_sel = 32'd0;
        // Fetch fault is oldest in the pipe, so it outranks everything
        if (info[INFO_PCADDR]) begin
            excode      = EXC_ADEL;
            badaddr_sel = pc;
        end else if (info[INFO_RI]) begin
            excode = EXC_RI;
        end else if (info[INFO_OV]) begin
            excode = EXC_OV;
        end else if (info[INFO_SYS]) begin
            excode = EXC_SYS;
        end else if (info[INFO_BRK]) begin
            excode = EXC_BP;
        end else if (info[INFO_ADEL]) begin
            excode      = EXC_ADEL;
            badaddr_sel = badaddr;
        end else if (info[INFO_ADES]) begin
            excode      = EXC_ADES;
            badaddr_sel = badaddr;
        end
    end

endmodule

// File: rtl/cp0_req_sched.sv
// -----------------------------------------------------------------------------
// cp0_req_sched
// Scheduler in front of the single-ported CP0 register file of the dual-issue
// core. Arbitrates exceptions, eret, mtc0 and mfc0 from both issue slots,
// serialises a double CP0 access with a one-cycle stall, injects synchronised
// hardware interrupts on i1 and sequences the post-exception flush window.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i1_*/i2_*                slot valid, exception info, pc, mtc0 data,
//                            faulting data address (i1 is the older slot)
//   hw_int                   asynchronous interrupt lines
//   st_ie, st_exl, im        Status fields fed back from CP0
//   cp0_we/re/addr/wdata     register access strobe, number and data
//   cp0_except/excode        exception commit strobe and ExcCode
//   cp0_eret                 eret commit strobe
//   cp0_pc/badaddr/bd        EPC source, BadVAddr source, delay-slot flag
//   ip_hw                    synchronised interrupt lines for Cause.IP[7:2]
//   stall, kill_i2, flush    pipeline control
// -----------------------------------------------------------------------------
module cp0_req_sched
    import cp0_req_sched_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int HWINT_W      = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i1_valid,
    input  logic [EXCEPTINFO_WD-1:0] i1_info,
    input  logic [31:0]              i1_pc,
    input  logic [31:0]              i1_wdata,
    input  logic [31:0]              i1_badaddr,
    input  logic                     i2_valid,
    input  logic [EXCEPTINFO_WD-1:0] i2_info,
    input  logic [31:0]              i2_pc,
    input  logic [31:0]              i2_wdata,
    input  logic [31:0]              i2_badaddr,
    input  logic [HWINT_W-1:0]       hw_int,
    input  logic                     st_ie,
    input  logic                     st_exl,
    input  logic [7:0]               im,
    output logic                     cp0_we,
    output logic                     cp0_re,
    output logic [4:0]               cp0_addr,
    output logic [31:0]              cp0_wdata,
    output logic                     cp0_except,
    output logic [4:0]               cp0_excode,
    output logic                     cp0_eret,
    output logic [31:0]              cp0_pc,
    output logic [31:0]              cp0_badaddr,
    output logic                     cp0_bd,
    output logic [HWINT_W-1:0]       ip_hw,
    output logic                     stall,
    output logic                     kill_i2,
    output logic                     flush
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic [2:0]               flush_cnt;
    logic [HWINT_W-1:0]       sync1;
    logic [HWINT_W-1:0]       sync2;
    logic                     int_pend;

    logic [EXCEPTINFO_WD-1:0] lat_info;
    logic [31:0]              lat_pc;
    logic [31:0]              lat_wdata;
    logic [31:0]              lat_badaddr;

    logic unused_im;
    assign unused_im = ^im[1:0];

    // In SERVE2 the second prioritiser looks at the latched i2 instead of
    // the live slot, so one instance serves both uses.
    logic                     s2_valid;
    logic [EXCEPTINFO_WD-1:0] s2_info;
    logic [31:0]              s2_pc;
    logic [31:0]              s2_wdata;
    logic [31:0]              s2_badaddr;

    assign s2_valid   = (state == SERVE2) | i2_valid;
    assign s2_info    = (state == SERVE2) ? lat_info    : i2_info;
    assign s2_pc      = (state == SERVE2) ? lat_pc      : i2_pc;
    assign s2_wdata   = (state == SERVE2) ? lat_wdata   : i2_wdata;
    assign s2_badaddr = (state == SERVE2) ? lat_badaddr : i2_badaddr;

    logic        p1_exc,  p2_exc;
    logic [4:0]  p1_code, p2_code;
    logic [31:0] p1_bad,  p2_bad;

    cp0_exc_prio u_prio1 (
        .info        (i1_info),
        .pc          (i1_pc),
        .badaddr     (i1_badaddr),
        .exc         (p1_exc),
        .excode      (p1_code),
        .badaddr_sel (p1_bad)
    );

    cp0_exc_prio u_prio2 (
        .info        (s2_info),
        .pc          (s2_pc),
        .badaddr     (s2_badaddr),
        .exc         (p2_exc),
        .excode      (p2_code),
        .badaddr_sel (p2_bad)
    );

    req_t r1, r2, r_int, sel;
    logic s1_big, s1_acc, s2_big, s2_acc, s2_need;
    logic stall_c, kill_c, flush_c, latch_c;

    assign r1 = build_req(p1_exc, p1_code, p1_bad, i1_info, i1_pc, i1_wdata);
    assign r2 = build_req(p2_exc, p2_code, p2_bad, s2_info, s2_pc, s2_wdata);

    // "big" = exception or eret: either one ends in a flush
    assign s1_big  = i1_valid & (p1_exc | i1_info[INFO_ERET]);
    assign s1_acc  = i1_valid & (i1_info[INFO_MTC0] | i1_info[INFO_MFC0]);
    assign s2_big  = s2_valid & (p2_exc | s2_info[INFO_ERET]);
    assign s2_acc  = s2_valid & (s2_info[INFO_MTC0] | s2_info[INFO_MFC0]);
    assign s2_need = s2_big | s2_acc;

    always_comb begin
        r_int        = '0;
        r_int.except = 1'b1;
        r_int.excode = EXC_INT;
        r_int.pc     = i1_pc;
        r_int.bd     = i1_info[INFO_BD];
    end

    always_comb begin
        sel       = '0;
        stall_c   = 1'b0;
        kill_c    = 1'b0;
        flush_c   = 1'b0;
        latch_c   = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (int_pend && i1_valid) begin
                    sel       = r_int;
                    kill_c    = 1'b1;
                    state_nxt = FLUSH;
                end else if (s1_big) begin
                    sel       = r1;
                    kill_c    = 1'b1;
                    state_nxt = FLUSH;
                end else if (s1_acc && s2_need) begin
                    sel       = r1;
                    stall_c   = 1'b1;
                    latch_c   = 1'b1;
                    state_nxt = SERVE2;
                end else if (s1_acc) begin
                    sel = r1;
                end else if (s2_big) begin
                    sel       = r2;
                    state_nxt = FLUSH;
                end else if (s2_acc) begin
                    sel = r2;
                end
            end
            SERVE2: begin
                // Latched i2 always needed CP0; interrupts wait a cycle
                sel       = r2;
                state_nxt = s2_big ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush_c = 1'b1;
                if (flush_cnt == 3'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            flush_cnt <= 3'd0;
            sync1     <= '0;
            sync2     <= '0;
            int_pend  <= 1'b0;
        end else begin
            sync1    <= hw_int;
            sync2    <= sync1;
            int_pend <= (|(sync2 & im[7:2])) & st_ie & ~st_exl;
            state    <= state_nxt;
            if (state != FLUSH && state_nxt == FLUSH) begin
                flush_cnt <= FLUSH_LOAD;
            end else if (state == FLUSH && flush_cnt != 3'd0) begin
                flush_cnt <= flush_cnt - 3'd1;
            end
        end
    end

    // Held i2 fields for the SERVE2 cycle; pure data, no reset needed
    always_ff @(posedge clk) begin
        if (latch_c) begin
            lat_info    <= i2_info;
            lat_pc      <= i2_pc;
            lat_wdata   <= i2_wdata;
            lat_badaddr <= i2_badaddr;
        end
    end

    // Outputs are forced low while reset is asserted, independent of inputs
    assign cp0_we      = rst & sel.we;
    assign cp0_re      = rst & sel.re;
    assign cp0_addr    = rst ? sel.addr    : 5'd0;
    assign cp0_wdata   = rst ? sel.wdata   : 32'd0;
    assign cp0_except  = rst & sel.except;
    assign cp0_excode  = rst ? sel.excode  : 5'd0;
    assign cp0_eret    = rst & sel.eret;
    assign cp0_pc      = rst ? sel.pc      : 32'd0;
    assign cp0_badaddr = rst ? sel.badaddr : 32'd0;
    assign cp0_bd      = rst & sel.bd;
    assign stall       = rst & stall_c;
    assign kill_i2     = rst & kill_c;
    assign flush       = rst & flush_c;
    assign ip_hw       = sync2;

endmodule
